// File: rtl/vref_sweep_cal_rx.sv
// Receiver Vref calibration for MBTRAIN RX: sideband start/end handshake, Vref sweep with
// per-code point tests, longest-passing-window tracking and centre programming.
module vref_sweep_cal_rx #(
    parameter int NUM_LANES     = 16,
    parameter int VREF_W        = 4,
    parameter int VREF_MIN      = 0,
    parameter int VREF_MAX      = 15,
    parameter int VREF_STEP     = 1,
    parameter int VREF_DEFAULT  = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [3:0]           i_decoded_sideband_message,
    input  logic                 i_sideband_valid,
    input  logic                 i_busy_negedge_detected,
    input  logic                 i_valid_tx,
    input  logic                 i_pt_done,
    input  logic [NUM_LANES-1:0] i_rx_lanes_result,
    input  logic [NUM_LANES-1:0] i_lane_mask,
    output logic [3:0]           o_sideband_message,
    output logic                 o_valid_rx,
    output logic                 o_pt_en,
    output logic [VREF_W-1:0]    o_reciever_ref_voltage,
    output logic                 o_test_ack,
    output logic                 o_cal_pass,
    output logic [VREF_W:0]      o_best_width
);

    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;

    localparam logic [VREF_W:0]   STEP_X = (VREF_W+1)'(VREF_STEP);
    localparam logic [VREF_W:0]   MAX_X  = (VREF_W+1)'(VREF_MAX);
    localparam logic [VREF_W-1:0] MIN_C  = VREF_W'(VREF_MIN);
    localparam logic [VREF_W-1:0] DEF_C  = VREF_W'(VREF_DEFAULT);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_START,
        SEND_START_RESP,
        SET_CODE,
        RUN_PT,
        EVAL,
        FINALIZE,
        WAIT_END,
        SEND_END_RESP,
        DONE
    } state_t;

    state_t            state;
    logic [VREF_W-1:0] code;
    logic [CNT_W-1:0]  settle_cnt;
    logic              pt_pass_q;
    logic [VREF_W-1:0] cur_start;
    logic [VREF_W-1:0] best_start;
    logic [VREF_W:0]   cur_len;
    logic [VREF_W:0]   best_len;
    logic              end_seen;
    logic              req_pending;

    logic              lane_pass;
    logic              start_req;
    logic              end_req;
    logic [VREF_W:0]   next_code_x;
    logic              sweep_last;
    logic [VREF_W:0]   cur_len_inc;
    logic [VREF_W-1:0] win_start;
    logic [VREF_W:0]   half_span;
    logic [VREF_W:0]   centre_x;

    // Unmasked lanes are forced to pass; an empty mask can never pass.
    assign lane_pass   = (&(i_rx_lanes_result | ~i_lane_mask)) & (|i_lane_mask);
    assign start_req   = i_sideband_valid && (i_decoded_sideband_message == MSG_START_REQ);
    assign end_req     = i_sideband_valid && (i_decoded_sideband_message == MSG_END_REQ);
    assign next_code_x = {1'b0, code} + STEP_X;
    assign sweep_last  = next_code_x > MAX_X;
    assign cur_len_inc = cur_len + 1'b1;
    assign win_start   = (cur_len == '0) ? code : cur_start;
    assign half_span   = (best_len - 1'b1) >> 1;
    assign centre_x    = {1'b0, best_start} + half_span * STEP_X;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            code                   <= '0;
            settle_cnt             <= '0;
            pt_pass_q              <= 1'b0;
            cur_start              <= '0;
            best_start             <= '0;
            cur_len                <= '0;
            best_len               <= '0;
            end_seen               <= 1'b0;
            req_pending            <= 1'b0;
            o_sideband_message     <= '0;
            o_valid_rx             <= 1'b0;
            o_pt_en                <= 1'b0;
            o_reciever_ref_voltage <= DEF_C;
            o_test_ack             <= 1'b0;
            o_cal_pass             <= 1'b0;
            o_best_width           <= '0;
        end else if (!i_en) begin
            // Vref deliberately keeps its last value so the analog side is not disturbed.
            state              <= IDLE;
            code               <= '0;
            settle_cnt         <= '0;
            pt_pass_q          <= 1'b0;
            cur_start          <= '0;
            best_start         <= '0;
            cur_len            <= '0;
            best_len           <= '0;
            end_seen           <= 1'b0;
            req_pending        <= 1'b0;
            o_sideband_message <= '0;
            o_valid_rx         <= 1'b0;
            o_pt_en            <= 1'b0;
            o_test_ack         <= 1'b0;
            o_cal_pass         <= 1'b0;
            o_best_width       <= '0;
        end else begin
            // Busy negedge ends our send and also blocks a rise in the same cycle.
            if (o_valid_rx && i_busy_negedge_detected) begin
                o_valid_rx  <= 1'b0;
                req_pending <= 1'b0;
            end else if (req_pending && !o_valid_rx && !i_valid_tx && !i_busy_negedge_detected) begin
                o_valid_rx <= 1'b1;
            end

            if (end_req && (state inside {SEND_START_RESP, SET_CODE, RUN_PT, EVAL, FINALIZE}))
                end_seen <= 1'b1;

            case (state)
                IDLE: begin
                    end_seen <= 1'b0;
                    state    <= WAIT_START;
                end
                WAIT_START: begin
                    if (start_req) begin
                        state              <= SEND_START_RESP;
                        o_sideband_message <= MSG_START_RESP;
                        req_pending        <= 1'b1;
                    end
                end
                SEND_START_RESP: begin
                    if (!req_pending && !o_valid_rx) begin
                        state                  <= SET_CODE;
                        code                   <= MIN_C;
                        o_reciever_ref_voltage <= MIN_C;
                        settle_cnt             <= '0;
                        o_sideband_message     <= '0;
                        cur_start              <= '0;
                        best_start             <= '0;
                        cur_len                <= '0;
                        best_len               <= '0;
                    end
                end
                SET_CODE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        o_pt_en    <= 1'b1;
                        state      <= RUN_PT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN_PT: begin
                    if (i_pt_done) begin
                        o_pt_en   <= 1'b0;
                        pt_pass_q <= lane_pass;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    // Strict compare keeps the earliest window on ties.
                    if (pt_pass_q) begin
                        cur_start <= win_start;
                        cur_len   <= cur_len_inc;
                        if (cur_len_inc > best_len) begin
                            best_start <= win_start;
                            best_len   <= cur_len_inc;
                        end
                    end else begin
                        cur_len <= '0;
                    end
                    if (sweep_last) begin
                        state <= FINALIZE;
                    end else begin
                        code                   <= next_code_x[VREF_W-1:0];
                        o_reciever_ref_voltage <= next_code_x[VREF_W-1:0];
                        state                  <= SET_CODE;
                    end
                end
                FINALIZE: begin
                    if (best_len != '0) begin
                        o_reciever_ref_voltage <= centre_x[VREF_W-1:0];
                        o_cal_pass             <= 1'b1;
                        o_best_width           <= best_len;
                    end else begin
                        o_reciever_ref_voltage <= DEF_C;
                        o_cal_pass             <= 1'b0;
                        o_best_width           <= '0;
                    end
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    if (end_seen || end_req) begin
                        state              <= SEND_END_RESP;
                        o_sideband_message <= MSG_END_RESP;
                        req_pending        <= 1'b1;
                    end
                end
                SEND_END_RESP: begin
                    if (!req_pending && !o_valid_rx) begin
                        state              <= DONE;
                        o_sideband_message <= '0;
                        o_test_ack         <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vref_sweep_cal_rx.sv
// Scoreboard bench for vref_sweep_cal_rx: a STEP=1 instance and a STEP=3 instance share the
// sideband inputs; expected responses are queued at stimulus time and popped by a monitor.
module tb_vref_sweep_cal_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dec_msg;
    logic       sb_valid;
    logic       valid_tx;
    logic [3:0] lane_mask;
    logic [1:0] en;
    logic [1:0] busy;
    logic [1:0] pt_done;
    logic [3:0] lanes [2];

    logic [3:0] sb_msg [2];
    logic [1:0] valid_rx;
    logic [1:0] pt_en;
    logic [1:0] test_ack;
    logic [1:0] cal_pass;
    logic [3:0] vref [2];
    logic [4:0] width [2];

    logic       pass_tab [16];
    logic [3:0] lane_force;
    int         pt_cnt [2];
    int         cyc;
    int         compares = 0;
    int         errors = 0;

    typedef struct {
        int         dut;
        bit         is_result;
        logic [3:0] msg;
        logic [3:0] vref;
        logic [4:0] width;
        logic       pass;
        int         pts;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    vref_sweep_cal_rx #(.NUM_LANES(4), .VREF_W(4), .VREF_MIN(0), .VREF_MAX(15), .VREF_STEP(1),
                        .VREF_DEFAULT(8), .SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .i_en(en[0]),
        .i_decoded_sideband_message(dec_msg), .i_sideband_valid(sb_valid),
        .i_busy_negedge_detected(busy[0]), .i_valid_tx(valid_tx),
        .i_pt_done(pt_done[0]), .i_rx_lanes_result(lanes[0]), .i_lane_mask(lane_mask),
        .o_sideband_message(sb_msg[0]), .o_valid_rx(valid_rx[0]), .o_pt_en(pt_en[0]),
        .o_reciever_ref_voltage(vref[0]), .o_test_ack(test_ack[0]),
        .o_cal_pass(cal_pass[0]), .o_best_width(width[0])
    );

    vref_sweep_cal_rx #(.NUM_LANES(4), .VREF_W(4), .VREF_MIN(0), .VREF_MAX(15), .VREF_STEP(3),
                        .VREF_DEFAULT(8), .SETTLE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .i_en(en[1]),
        .i_decoded_sideband_message(dec_msg), .i_sideband_valid(sb_valid),
        .i_busy_negedge_detected(busy[1]), .i_valid_tx(valid_tx),
        .i_pt_done(pt_done[1]), .i_rx_lanes_result(lanes[1]), .i_lane_mask(lane_mask),
        .o_sideband_message(sb_msg[1]), .o_valid_rx(valid_rx[1]), .o_pt_en(pt_en[1]),
        .o_reciever_ref_voltage(vref[1]), .o_test_ack(test_ack[1]),
        .o_cal_pass(cal_pass[1]), .o_best_width(width[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic set_window(input int lo1, input int hi1, input int lo2, input int hi2);
        for (int i = 0; i < 16; i++)
            pass_tab[i] = ((i >= lo1) && (i <= hi1)) || ((i >= lo2) && (i <= hi2));
    endtask

    task automatic send_sb(input logic [3:0] msg);
        dec_msg  = msg;
        sb_valid = 1'b1;
        @(posedge clk); #1;
        sb_valid = 1'b0;
        dec_msg  = 4'b0000;
    endtask

    task automatic wait_pts(input int d, input int n);
        int t;
        t = 0;
        while ((pt_cnt[d] < n) && (t < 2000)) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) begin
            compares++;
            errors++;
            $display("[TB] FAIL pt_timeout dut%0d: got %0d tests, expected %0d", d, pt_cnt[d], n);
        end
    endtask

    task automatic push_sb(input int d, input logic [3:0] msg, input int pts);
        exp_t e;
        e.dut = d; e.is_result = 1'b0; e.msg = msg; e.vref = '0; e.width = '0; e.pass = 1'b0; e.pts = pts;
        exp_q.push_back(e);
    endtask

    // One full calibration: start handshake, sweep, end handshake, result, disable.
    task automatic applyStimulus(input int d, input logic [3:0] evref, input logic [4:0] ewidth,
                                 input logic epass, input int epts, input bit end_mid, input bit vtx_hold);
        exp_t e;
        int   t;
        en[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_sb(d, 4'b0010, -1);
        push_sb(d, 4'b0100, epts);
        e.dut = d; e.is_result = 1'b1; e.msg = '0; e.vref = evref; e.width = ewidth; e.pass = epass; e.pts = epts;
        exp_q.push_back(e);
        valid_tx = vtx_hold;
        send_sb(4'b0001);
        if (vtx_hold) begin
            repeat (4) begin
                @(posedge clk); #1;
                checkOutput("valid_rx_deferred", valid_rx[d], 1'b0);
            end
            valid_tx = 1'b0;
        end
        if (end_mid) begin
            wait_pts(d, 3);
            send_sb(4'b0011);
        end else begin
            wait_pts(d, epts);
            repeat (3) @(posedge clk);
            #1;
            send_sb(4'b0011);
        end
        t = 0;
        while (!test_ack[d] && (t < 3000)) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) begin
            compares++;
            errors++;
            $display("[TB] FAIL ack_timeout dut%0d: got ack %b, expected 1", d, test_ack[d]);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("ack_sticky", test_ack[d], 1'b1);
        end
        en[d] = 1'b0;
        @(posedge clk); #1;
        checkOutput("ack_clear", test_ack[d], 1'b0);
        checkOutput("cal_pass_clear", cal_pass[d], 1'b0);
        checkOutput("vref_hold", vref[d], evref);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Point-test and sideband-TX responder for both instances.
    initial begin
        int         bcnt [2];
        logic [1:0] prev_pt;
        logic [3:0] prev_v [2];
        int         last_chg [2];
        busy = '0; pt_done = '0; prev_pt = '0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            lanes[d] = '0; bcnt[d] = 0; prev_v[d] = 4'd8; last_chg[d] = 0; pt_cnt[d] = 0;
        end
        forever begin
            @(posedge clk); #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (vref[d] !== prev_v[d]) last_chg[d] = cyc;
                prev_v[d] = vref[d];
                if (!en[d]) pt_cnt[d] = 0;
                if (pt_en[d] && !prev_pt[d]) begin
                    pt_cnt[d]++;
                    checkOutput("settle_gap", cyc - last_chg[d], 2);
                end
                prev_pt[d] = pt_en[d];
                if (pt_done[d]) begin
                    pt_done[d] = 1'b0;
                end else if (pt_en[d]) begin
                    pt_done[d] = 1'b1;
                    lanes[d]   = pass_tab[vref[d]] ? lane_force : 4'b0000;
                end
                if (busy[d]) begin
                    busy[d] = 1'b0;
                end else if (valid_rx[d]) begin
                    bcnt[d]++;
                    if (bcnt[d] >= 3) begin
                        busy[d] = 1'b1;
                        bcnt[d] = 0;
                    end
                end else begin
                    bcnt[d] = 0;
                end
            end
        end
    end

    // Monitor: every sideband send and every completion pops the next expectation.
    initial begin
        logic [1:0] pv;
        logic [1:0] pa;
        exp_t       e;
        pv = '0;
        pa = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (valid_rx[d] && !pv[d]) begin
                    if (exp_q.size() == 0) begin
                        compares++;
                        errors++;
                        $display("[TB] FAIL unexpected_send dut%0d: got msg %b, expected none", d, sb_msg[d]);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("send_dut", d, e.dut);
                        checkOutput("send_is_message", 1'b0, e.is_result);
                        checkOutput("send_msg", sb_msg[d], e.msg);
                        if (e.pts >= 0) checkOutput("tests_before_end_resp", pt_cnt[d], e.pts);
                    end
                end
                if (test_ack[d] && !pa[d]) begin
                    if (exp_q.size() == 0) begin
                        compares++;
                        errors++;
                        $display("[TB] FAIL unexpected_ack dut%0d: got ack, expected none", d);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("ack_dut", d, e.dut);
                        checkOutput("ack_is_result", 1'b1, e.is_result);
                        checkOutput("result_vref", vref[d], e.vref);
                        checkOutput("result_width", width[d], e.width);
                        checkOutput("result_pass", cal_pass[d], e.pass);
                        checkOutput("result_tests", pt_cnt[d], e.pts);
                        checkOutput("result_msg_idle", sb_msg[d], 4'b0000);
                    end
                end
                pv[d] = valid_rx[d];
                pa[d] = test_ack[d];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; en = '0; dec_msg = '0; sb_valid = 1'b0; valid_tx = 1'b0;
        lane_mask = 4'hF; lane_force = 4'hF;
        set_window(5, 11, 20, 19);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_msg", sb_msg[0], 4'b0000);
        checkOutput("rst_valid_rx", valid_rx[0], 1'b0);
        checkOutput("rst_pt_en", pt_en[0], 1'b0);
        checkOutput("rst_vref", vref[0], 4'd8);
        checkOutput("rst_ack", test_ack[0], 1'b0);
        checkOutput("rst_cal_pass", cal_pass[0], 1'b0);
        checkOutput("rst_width", width[0], 5'd0);
        checkOutput("rst_vref_step3", vref[1], 4'd8);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] window 5..11, TX owns mux at start request");
        applyStimulus(0, 4'd8, 5'd7, 1'b1, 16, 1'b0, 1'b1);

        $display("[TB] tied windows 2..4 and 9..11");
        set_window(2, 4, 9, 11);
        applyStimulus(0, 4'd3, 5'd3, 1'b1, 16, 1'b0, 1'b0);

        $display("[TB] windows 2..3 and 9..11, end request mid-sweep");
        set_window(2, 3, 9, 11);
        applyStimulus(0, 4'd10, 5'd3, 1'b1, 16, 1'b1, 1'b0);

        $display("[TB] lane 2 failing but masked off");
        set_window(5, 11, 20, 19);
        lane_force = 4'b1011;
        lane_mask  = 4'b1011;
        applyStimulus(0, 4'd8, 5'd7, 1'b1, 16, 1'b0, 1'b0);

        $display("[TB] empty lane mask");
        lane_force = 4'hF;
        lane_mask  = 4'b0000;
        applyStimulus(0, 4'd8, 5'd0, 1'b0, 16, 1'b0, 1'b0);

        $display("[TB] enable dropped mid-sweep, then restart");
        lane_mask = 4'hF;
        en[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_sb(0, 4'b0010, -1);
        send_sb(4'b0001);
        wait_pts(0, 4);
        en[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_pt_en", pt_en[0], 1'b0);
        checkOutput("abort_ack", test_ack[0], 1'b0);
        checkOutput("abort_valid_rx", valid_rx[0], 1'b0);
        checkOutput("abort_msg", sb_msg[0], 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(0, 4'd8, 5'd7, 1'b1, 16, 1'b0, 1'b0);

        $display("[TB] step 3 sweep, passing codes 6,9,12");
        set_window(6, 12, 20, 19);
        applyStimulus(1, 4'd9, 5'd3, 1'b1, 6, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
